// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port writeback arbiter with starvation guard and optional bypass (WB_BYPASS_EN)
module regfile_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    // ALU writeback requester
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    // load / multicycle writeback requester
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    // register-file write port
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    // decode-stage read indices and bypass results
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);

    // Counter wide enough for STARVE_LIMIT, never narrower than two bits.
    localparam int CW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]   starve_q, starve_d;
    logic            starve_at_limit;
    logic            grant0, grant1;

    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    assign starve_at_limit = (starve_q == LIMIT);

    // Grant selection: req0 has priority unless req1 has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                if (starve_at_limit) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Starvation counter: counts req1's consecutive losses, saturating; any win or idle clears it.
    always_comb begin
        starve_d = '0;
        if (req1_valid && !grant1) begin
            starve_d = starve_at_limit ? starve_q : starve_q + 1'b1;
        end
    end

    // Next writeback stage: capture the winner; rd=0 keeps the handshake but suppresses the write.
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant0) begin
            we_d   = (req0_rd != 5'd0);
            rd_d   = req0_rd;
            data_d = req0_data;
        end else if (grant1) begin
            we_d   = (req1_rd != 5'd0);
            rd_d   = req1_rd;
            data_d = req1_data;
        end
    end

    // State registers; reset drops any write that was captured but not yet presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_rd    = rd_q;
    assign rf_wdata = data_q;

`ifdef WB_BYPASS_EN
    // The write being presented this cycle is forwarded to matching nonzero read indices.
    always_comb begin
        fwd1_hit  = we_q && (rd_q == rs1) && (rs1 != 5'd0);
        fwd2_hit  = we_q && (rd_q == rs2) && (rs2 != 5'd0);
        fwd1_data = data_q;
        fwd2_data = data_q;
    end
`else
    // Bypass disabled: outputs tied low, read indices intentionally unused.
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int XLEN  = 64;
    localparam int LIMIT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]      req0_rd = 5'd0, req1_rd = 5'd0;
    logic [XLEN-1:0] req0_data = '0, req1_data = '0;
    logic            req0_ready, req1_ready;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      rs1 = 5'd0, rs2 = 5'd0;
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;

    int passed = 0;
    int total  = 0;

    // Reference model: arbitration history and the write currently presented.
    int              m_starve = 0;
    logic            m_we = 1'b0;
    logic [4:0]      m_rd = 5'd0;
    logic [XLEN-1:0] m_data = '0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // -1 none, 0 req0, 1 req1
    function automatic int model_grant();
        if (reset) return -1;
        if (req0_valid && req1_valid) return (m_starve == LIMIT) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // One cycle: drive, check combinational outputs mid-cycle, clock, check registered outputs.
    task automatic step(input logic v0, input logic [4:0] rd0, input logic [XLEN-1:0] d0,
                        input logic v1, input logic [4:0] rd1, input logic [XLEN-1:0] d1,
                        input logic [4:0] s1, input logic [4:0] s2,
                        output logic r0s, output logic r1s);
        int  g;
        logic h1, h2;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
        rs1 = s1; rs2 = s2;
        #3;
        g = model_grant();
        r0s = req0_ready;
        r1s = req1_ready;
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        if (!reset) begin
            h1 = BYPASS && m_we && (m_rd == s1) && (s1 != 5'd0);
            h2 = BYPASS && m_we && (m_rd == s2) && (s2 != 5'd0);
            chk("fwd1_hit", fwd1_hit, h1);
            chk("fwd2_hit", fwd2_hit, h2);
            if (h1 || !BYPASS) chk("fwd1_data", fwd1_data, h1 ? m_data : '0);
            if (h2 || !BYPASS) chk("fwd2_data", fwd2_data, h2 ? m_data : '0);
        end
        @(posedge clk);
        if (reset) begin
            m_starve = 0; m_we = 1'b0; m_rd = 5'd0; m_data = '0;
        end else begin
            if (g == 1) m_starve = 0;
            else if (v1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else m_starve = 0;
            if (g == 0) begin m_we = (rd0 != 0); m_rd = rd0; m_data = d0; end
            else if (g == 1) begin m_we = (rd1 != 0); m_rd = rd1; m_data = d1; end
            else m_we = 1'b0;
        end
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_wdata", rf_wdata, m_data);
    endtask

    typedef struct {
        logic v0; logic [4:0] rd0; logic [XLEN-1:0] d0;
        logic v1; logic [4:0] rd1; logic [XLEN-1:0] d1;
        logic r0; logic r1;
        logic we; logic [4:0] rd; logic [XLEN-1:0] wd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic r0s, r1s;
        tbl[0] = '{1, 5, 64'hAA, 0, 0, 0,      1, 0, 1, 5, 64'hAA};
        tbl[1] = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 5, 64'hAA};
        tbl[2] = '{0, 0, 0,      1, 0, 64'h55, 0, 1, 0, 0, 64'h55};
        tbl[3] = '{0, 0, 0,      1, 3, 64'h33, 0, 1, 1, 3, 64'h33};
        tbl[4] = '{1, 1, 64'h11, 1, 2, 64'h22, 1, 0, 1, 1, 64'h11};
        tbl[5] = '{1, 1, 64'h12, 1, 2, 64'h22, 1, 0, 1, 1, 64'h12};
        tbl[6] = '{0, 0, 0,      1, 2, 64'h22, 0, 1, 1, 2, 64'h22};
        tbl[7] = '{1, 1, 64'h13, 1, 2, 64'h23, 1, 0, 1, 1, 64'h13};
        tbl[8] = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 1, 64'h13};

        @(posedge clk); #1;
        // Reset with both requesters asserting: no grants, outputs cleared.
        reset = 1'b1;
        step(1, 4, 64'h44, 1, 6, 64'h66, 0, 0, r0s, r1s);
        step(1, 4, 64'h44, 1, 6, 64'h66, 0, 0, r0s, r1s);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_rd", rf_rd, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        reset = 1'b0;
        chk("post_reset_fwd1_hit", fwd1_hit, 0);
        chk("post_reset_fwd2_hit", fwd2_hit, 0);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1, 0, 0, r0s, r1s);
            chk($sformatf("tbl%0d_req0_ready", i), r0s, tbl[i].r0);
            chk($sformatf("tbl%0d_req1_ready", i), r1s, tbl[i].r1);
            chk($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].we);
            chk($sformatf("tbl%0d_rf_rd", i), rf_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].wd);
        end

        // Continuous contention: req0,req0,req0,req1 repeating, one write every cycle.
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1, 5'(1 + i), 64'(100 + i), 1, 5'(20 + i), 64'(200 + i), 0, 0, r0s, r1s);
            chk($sformatf("starve%0d_req1_ready", i), r1s, (i % 4) == 3);
            chk($sformatf("starve%0d_req0_ready", i), r0s, (i % 4) != 3);
            chk($sformatf("starve%0d_rf_we", i), rf_we, 1);
            chk($sformatf("starve%0d_rf_wdata", i), rf_wdata, ((i % 4) == 3) ? 64'(200 + i) : 64'(100 + i));
        end

        // Accepted write of rd=7 is discarded by a reset on the next edge.
        step(1, 7, 64'h77, 0, 0, 0, 0, 0, r0s, r1s);
        chk("rd7_accepted", r0s, 1);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
        chk("rd7_discard_we", rf_we, 0);
        chk("rd7_discard_wdata", rf_wdata, 0);
        chk("rd7_discard_rd", rf_rd, 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
        chk("rd7_never_written", rf_we, 0);

        // Bypass of the presented write.
        step(1, 9, 64'h1234, 0, 0, 0, 0, 0, r0s, r1s);
        req0_valid = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
        #1;
        chk("byp_fwd1_hit", fwd1_hit, BYPASS);
        chk("byp_fwd1_data", fwd1_data, BYPASS ? 64'h1234 : 64'h0);
        chk("byp_fwd2_hit", fwd2_hit, 0);
        @(posedge clk); #1;
        m_we = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r0s, r1s);
            chk("rand_one_hot", r0s & r1s, 0);
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
